// File: rtl/room_navigator.sv
// Player motion and room transitions: latches a move at frame start, probes the
// moved box against mapData during the scan, and commits or rejects it at frame end.
module room_navigator #(
    parameter int PLAYER_SIZE = 8,
    parameter int STEP        = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MAP_LATENCY = 1,
    parameter int START_MAPX  = 3,
    parameter int START_MAPY  = 5,
    parameter int START_PX    = 316,
    parameter int START_PY    = 300
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic [9:0] CurrentX,
    input  logic [8:0] CurrentY,
    input  logic [7:0] mapData,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] mapX,
    output logic [3:0] mapY,
    output logic [9:0] playerX,
    output logic [8:0] playerY,
    output logic       collision,
    output logic       room_change
);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, EDGE} state_t;

    localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - PLAYER_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - PLAYER_SIZE);
    localparam logic signed [10:0] BOX_M1 = 11'(PLAYER_SIZE - 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    state_t                      state;
    logic [MAP_LATENCY-1:0][9:0] x_pipe;
    logic [MAP_LATENCY-1:0][8:0] y_pipe;
    logic [MAP_LATENCY-1:0]      vld_pipe;
    logic [9:0]                  px_d;
    logic [8:0]                  py_d;
    logic signed [10:0]          sx, sy, dx, dy, cand_x, cand_y;
    logic                        frame_start, frame_end, hit, blocked;
    logic [9:0]                  nx_x;
    logic [8:0]                  nx_y;
    logic [3:0]                  nx_mx, nx_my;

    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            x_pipe   <= '0;
            y_pipe   <= '0;
            vld_pipe <= '0;
        end else begin
            x_pipe[0]   <= CurrentX;
            y_pipe[0]   <= CurrentY;
            vld_pipe[0] <= 1'b1;
            for (int i = 1; i < MAP_LATENCY; i++) begin
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign px_d = x_pipe[MAP_LATENCY-1];
    assign py_d = y_pipe[MAP_LATENCY-1];
    assign sx   = $signed({1'b0, px_d});
    assign sy   = $signed({2'b0, py_d});

    // The zeroed pipe after reset must not look like a frame start.
    assign frame_start = vld_pipe[MAP_LATENCY-1] && px_d == 10'd0 && py_d == 9'd0;
    assign frame_end   = vld_pipe[MAP_LATENCY-1] && px_d == 10'd0 && py_d == 9'(V_ACTIVE);

    assign dx = (btn_right && !btn_left) ? STEP_S : (btn_left && !btn_right) ? -STEP_S : '0;
    assign dy = (btn_down && !btn_up) ? STEP_S : (btn_up && !btn_down) ? -STEP_S : '0;

    assign hit = (sx >= cand_x) && (sx <= cand_x + BOX_M1) &&
                 (sy >= cand_y) && (sy <= cand_y + BOX_M1) &&
                 ({1'b0, px_d} < 11'(H_ACTIVE)) && (mapData != 8'd0);

    // Axes resolve independently, so a corner exit moves both rooms at once.
    always_comb begin
        nx_x  = cand_x[9:0];
        nx_mx = mapX;
        if (cand_x < 0) begin
            if (mapX != 4'd0) begin
                nx_mx = mapX - 4'd1;
                nx_x  = X_MAX[9:0];
            end else begin
                nx_x  = '0;
            end
        end else if (cand_x > X_MAX) begin
            if (mapX != 4'hF) begin
                nx_mx = mapX + 4'd1;
                nx_x  = '0;
            end else begin
                nx_x  = X_MAX[9:0];
            end
        end
        nx_y  = cand_y[8:0];
        nx_my = mapY;
        if (cand_y < 0) begin
            if (mapY != 4'd0) begin
                nx_my = mapY - 4'd1;
                nx_y  = Y_MAX[8:0];
            end else begin
                nx_y  = '0;
            end
        end else if (cand_y > Y_MAX) begin
            if (mapY != 4'hF) begin
                nx_my = mapY + 4'd1;
                nx_y  = '0;
            end else begin
                nx_y  = Y_MAX[8:0];
            end
        end
    end

    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cand_x      <= '0;
            cand_y      <= '0;
            blocked     <= 1'b0;
            collision   <= 1'b0;
            room_change <= 1'b0;
            mapX        <= 4'(START_MAPX);
            mapY        <= 4'(START_MAPY);
            playerX     <= 10'(START_PX);
            playerY     <= 9'(START_PY);
        end else begin
            room_change <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    cand_x  <= $signed({1'b0, playerX}) + dx;
                    cand_y  <= $signed({2'b0, playerY}) + dy;
                    blocked <= 1'b0;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (hit) blocked <= 1'b1;
                    if (frame_end) state <= COMMIT;
                end
                COMMIT: begin
                    collision <= blocked;
                    state     <= blocked ? IDLE : EDGE;
                end
                EDGE: begin
                    playerX     <= nx_x;
                    playerY     <= nx_y;
                    mapX        <= nx_mx;
                    mapY        <= nx_my;
                    room_change <= (nx_mx != mapX) || (nx_my != mapY);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_room_navigator.sv
// Bench for room_navigator: three instances (centre, right edge, world corner) share a
// compressed scan that only visits the pixels around each player box.
module tb_room_navigator;
    logic clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    logic       reset;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic [7:0] map_data;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [3:0] mx [3];
    logic [3:0] my [3];
    logic [9:0] px [3];
    logic [8:0] py [3];
    logic       col [3];
    logic       rc [3];

    room_navigator u_a (
        .clk_vga(clk_vga), .reset(reset), .CurrentX(cur_x), .CurrentY(cur_y), .mapData(map_data),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mapX(mx[0]), .mapY(my[0]), .playerX(px[0]), .playerY(py[0]),
        .collision(col[0]), .room_change(rc[0]));
    room_navigator #(.START_PX(632)) u_b (
        .clk_vga(clk_vga), .reset(reset), .CurrentX(cur_x), .CurrentY(cur_y), .mapData(map_data),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mapX(mx[1]), .mapY(my[1]), .playerX(px[1]), .playerY(py[1]),
        .collision(col[1]), .room_change(rc[1]));
    room_navigator #(.START_MAPX(0), .START_PX(0)) u_c (
        .clk_vga(clk_vga), .reset(reset), .CurrentX(cur_x), .CurrentY(cur_y), .mapData(map_data),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mapX(mx[2]), .mapY(my[2]), .playerX(px[2]), .playerY(py[2]),
        .collision(col[2]), .room_change(rc[2]));

    int s_px [3] = '{316, 632, 0};
    int s_mx [3] = '{3, 3, 0};
    int checks = 0, failures = 0;
    int m_px [3], m_py [3], m_mx [3], m_my [3], m_col [3], exp_pc [3];
    int rc_cnt [3] = '{0, 0, 0};
    int wmode = 0, wseed = 0, wdens = 0;
    int last_x = 0, last_y = 490;

    always @(negedge clk_vga)
        for (int i = 0; i < 3; i++) if (rc[i]) rc_cnt[i] <= rc_cnt[i] + 1;

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        int wm;
        int a_px, a_col, b_px, b_mx, b_pc, c_px, c_mx;
    } vec_t;
    vec_t vecs [7];

    function automatic logic [7:0] wall(input int x, input int y);
        if (y >= 480) return 8'd0;
        case (wmode)
            1: return (x >= 324 && x <= 330 && y >= 300 && y <= 307) ? 8'hFF : 8'd0;
            2: return (wdens != 0 && ((x * 31 + y * 17 + wseed) % wdens) == 0) ? 8'(1 + x % 200) : 8'd0;
            3: return 8'hFF;
            default: return 8'd0;
        endcase
    endfunction

    function automatic bit box_blocked(input int cx, input int cy);
        for (int yy = cy; yy < cy + 8; yy++)
            for (int xx = cx; xx < cx + 8; xx++)
                if (xx >= 0 && xx < 640 && yy >= 0 && yy < 480 && wall(xx, yy) != 8'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // mapData tracks the coordinate presented one cycle earlier (MAP_LATENCY=1).
    task automatic tick(input int x, input int y);
        @(posedge clk_vga); #1;
        map_data = wall(last_x, last_y);
        cur_x = 10'(x);
        cur_y = 9'(y);
        last_x = x;
        last_y = y;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_px[k] = s_px[k]; m_mx[k] = s_mx[k]; m_py[k] = 300; m_my[k] = 5; m_col[k] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] b);
        int cx, cy, omx, omy;
        for (int k = 0; k < 3; k++) begin
            cx = m_px[k] + 2 * (int'(b[0]) - int'(b[1]));
            cy = m_py[k] + 2 * (int'(b[2]) - int'(b[3]));
            exp_pc[k] = 0;
            m_col[k] = int'(box_blocked(cx, cy));
            if (m_col[k] == 0) begin
                omx = m_mx[k]; omy = m_my[k];
                if (cx < 0) begin
                    if (m_mx[k] > 0) begin m_mx[k]--; m_px[k] = 632; end else m_px[k] = 0;
                end else if (cx > 632) begin
                    if (m_mx[k] < 15) begin m_mx[k]++; m_px[k] = 0; end else m_px[k] = 632;
                end else m_px[k] = cx;
                if (cy < 0) begin
                    if (m_my[k] > 0) begin m_my[k]--; m_py[k] = 472; end else m_py[k] = 0;
                end else if (cy > 472) begin
                    if (m_my[k] < 15) begin m_my[k]++; m_py[k] = 0; end else m_py[k] = 472;
                end else m_py[k] = cy;
                exp_pc[k] = (omx != m_mx[k] || omy != m_my[k]) ? 1 : 0;
            end
        end
    endtask

    task automatic check_all(input string tag, input int snap0, input int snap1, input int snap2);
        int snap [3];
        snap = '{snap0, snap1, snap2};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_u%0d_px", tag, k), int'(px[k]), m_px[k]);
            chk($sformatf("%s_u%0d_py", tag, k), int'(py[k]), m_py[k]);
            chk($sformatf("%s_u%0d_mx", tag, k), int'(mx[k]), m_mx[k]);
            chk($sformatf("%s_u%0d_my", tag, k), int'(my[k]), m_my[k]);
            chk($sformatf("%s_u%0d_col", tag, k), int'(col[k]), m_col[k]);
            chk($sformatf("%s_u%0d_pulses", tag, k), rc_cnt[k] - snap[k], exp_pc[k]);
        end
    endtask

    // Buttons are scrambled after the first box window to prove only frame start counts.
    task automatic run_frame(input logic [3:0] b, input string tag);
        int s0, s1, s2, lo_y, hi_y, lo_x;
        s0 = rc_cnt[0]; s1 = rc_cnt[1]; s2 = rc_cnt[2];
        {btn_up, btn_down, btn_left, btn_right} = b;
        tick(0, 0);
        for (int k = 0; k < 3; k++) begin
            lo_y = (m_py[k] > 2) ? m_py[k] - 2 : 0;
            hi_y = (m_py[k] + 9 < 480) ? m_py[k] + 9 : 479;
            lo_x = (m_px[k] > 2) ? m_px[k] - 2 : 0;
            for (int y = lo_y; y <= hi_y; y++)
                for (int x = lo_x; x <= m_px[k] + 11; x++) tick(x, y);
            {btn_up, btn_down, btn_left, btn_right} = 4'($urandom_range(0, 15));
        end
        tick(0, 480);
        repeat (5) tick(0, 490);
        model_step(b);
        @(negedge clk_vga);
        check_all(tag, s0, s1, s2);
    endtask

    initial begin
        int s0, s1, s2;
        reset = 1'b0; cur_x = 10'd0; cur_y = 9'd490; map_data = 8'd0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        vecs[0] = '{4'b0001, 0, 318, 0, 0, 4, 1, 2, 0};
        vecs[1] = '{4'b0010, 0, 316, 0, 632, 3, 1, 0, 0};
        vecs[2] = '{4'b0010, 0, 314, 0, 630, 3, 0, 0, 0};
        vecs[3] = '{4'b0001, 0, 316, 0, 632, 3, 0, 2, 0};
        vecs[4] = '{4'b0001, 1, 316, 1, 0, 4, 1, 4, 0};
        vecs[5] = '{4'b0000, 1, 316, 0, 0, 4, 0, 4, 0};
        vecs[6] = '{4'b1100, 0, 316, 0, 0, 4, 0, 4, 0};

        repeat (3) @(posedge clk_vga);
        #1 reset = 1'b1;
        repeat (3) tick(0, 490);
        model_reset();
        for (int k = 0; k < 3; k++) exp_pc[k] = 0;
        @(negedge clk_vga);
        check_all("reset", rc_cnt[0], rc_cnt[1], rc_cnt[2]);

        for (int i = 0; i < 7; i++) begin
            s1 = rc_cnt[1];
            wmode = vecs[i].wm;
            run_frame(vecs[i].btn, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_a_px", i), int'(px[0]), vecs[i].a_px);
            chk($sformatf("tbl%0d_a_py", i), int'(py[0]), 300);
            chk($sformatf("tbl%0d_a_col", i), int'(col[0]), vecs[i].a_col);
            chk($sformatf("tbl%0d_b_px", i), int'(px[1]), vecs[i].b_px);
            chk($sformatf("tbl%0d_b_mx", i), int'(mx[1]), vecs[i].b_mx);
            chk($sformatf("tbl%0d_b_pulses", i), rc_cnt[1] - s1, vecs[i].b_pc);
            chk($sformatf("tbl%0d_c_px", i), int'(px[2]), vecs[i].c_px);
            chk($sformatf("tbl%0d_c_mx", i), int'(mx[2]), vecs[i].c_mx);
            chk($sformatf("tbl%0d_c_py", i), int'(py[2]), 300);
        end

        // Reset dropped mid-scan after the box has already hit walls.
        wmode = 3;
        s0 = rc_cnt[0]; s1 = rc_cnt[1]; s2 = rc_cnt[2];
        {btn_up, btn_down, btn_left, btn_right} = 4'b0001;
        tick(0, 0);
        for (int y = 298; y <= 309; y++)
            for (int x = 314; x <= 327; x++) tick(x, y);
        tick(5, 200);
        reset = 1'b0;
        @(negedge clk_vga);
        chk("rst_async_b_mx", int'(mx[1]), 3);
        chk("rst_async_b_px", int'(px[1]), 632);
        chk("rst_async_c_px", int'(px[2]), 0);
        tick(5, 250);
        tick(5, 300);
        reset = 1'b1;
        for (int y = 301; y <= 320; y++) tick(5, y);
        tick(0, 480);
        repeat (5) tick(0, 490);
        model_reset();
        for (int k = 0; k < 3; k++) exp_pc[k] = 0;
        @(negedge clk_vga);
        check_all("midrst", s0, s1, s2);
        wmode = 0;
        run_frame(4'b0001, "after_rst");

        wmode = 2;
        for (int f = 0; f < 60; f++) begin
            wseed = int'($urandom_range(0, 1000));
            case ($urandom_range(0, 3))
                0: wdens = 0;
                1: wdens = 61;
                2: wdens = 151;
                default: wdens = 401;
            endcase
            run_frame(4'($urandom_range(0, 15)), $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/room_navigator.md
# room_navigator

Player-motion and room-transition controller for the Adventure game, and the consumer of the map generator's per-pixel `mapData` stream. Once per VGA frame it latches the requested move and probes every pixel the moved player box would cover for a wall. At frame end it commits or rejects the move. When the player walks off a screen edge, it advances `mapX`/`mapY`, which feed back into the map generator to select the next room.

## Interface
Parameters:
- `PLAYER_SIZE`, 8: player box edge in pixels.
- `STEP`, 2: pixels moved per frame per axis.
- `H_ACTIVE`, 640: visible width.
- `V_ACTIVE`, 480: visible height.
- `MAP_LATENCY`, 1: cycles from `CurrentX`/`CurrentY` to the matching `mapData`.
- `START_MAPX`, 3: reset room X.
- `START_MAPY`, 5: reset room Y.
- `START_PX`, 316: reset player X.
- `START_PY`, 300: reset player Y.

Ports (clock and reset first):
- `clk_vga`  in  1  pixel clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `CurrentX`  in  10  scan column.
- `CurrentY`  in  9  scan row.
- `mapData`  in  8  map pixel colour; nonzero means wall.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  move requests, synchronous to `clk_vga`.
- `mapX`  out  4  current room X; north is lower Y.
- `mapY`  out  4  current room Y.
- `playerX`  out  10  player box left edge.
- `playerY`  out  9  player box top edge.
- `collision`  out  1  last frame's move was blocked.
- `room_change`  out  1  one-cycle pulse on a room transition.

## Operation
- Delay `CurrentX`/`CurrentY` by `MAP_LATENCY` registers to form `px_d`/`py_d`, aligned with `mapData`. All frame logic uses the delayed coordinates.
- Frame start: `px_d==0 && py_d==0`. Frame end: `px_d==0 && py_d==V_ACTIVE`.
- FSM has four states, `IDLE`, `SCAN`, `COMMIT`, `EDGE`:
  - **IDLE**: wait for frame start. On frame start, latch the move:
    - `dx = STEP*(right-left)`, `dy = STEP*(down-up)`. Opposing buttons cancel to 0.
    - `cand_x = playerX+dx`, `cand_y = playerY+dy`, both 11-bit signed.
    - Clear `blocked`.
    - Go to SCAN.
  - **SCAN**: each cycle, if `px_d` is in [cand_x, cand_x+PLAYER_SIZE-1], `py_d` is in the same range on cand_y, `px_d<H_ACTIVE`, and `mapData!=0`, set `blocked` (sticky). Off-screen parts of the box are never blocked. On frame end go to COMMIT.
  - **COMMIT**:
    - `collision <= blocked`.
    - If blocked, the position is unchanged; go to IDLE.
    - Otherwise go to EDGE carrying cand_x/cand_y.
  - **EDGE**: resolve X, then Y, independently in the same cycle, then write `playerX`, `playerY`, `mapX`, `mapY` and go to IDLE.
    - cand_x<0, mapX>0: mapX−1, playerX=H_ACTIVE−PLAYER_SIZE.
    - cand_x<0, mapX==0: playerX=0, no room change.
    - cand_x>H_ACTIVE−PLAYER_SIZE, mapX<15: mapX+1, playerX=0.
    - cand_x>H_ACTIVE−PLAYER_SIZE, mapX==15: playerX=H_ACTIVE−PLAYER_SIZE, no room change.
    - Y follows the same rules with V_ACTIVE and mapY.
    - Otherwise playerX=cand_x, playerY=cand_y.
    - `room_change=1` for this cycle if mapX or mapY changed. A diagonal corner exit changes both and gives a single pulse.
- Buttons are sampled only at frame start; changes mid-frame are ignored until the next frame.

## Timing
- Reset values, applied asynchronously while `reset==0`:
  - FSM=IDLE, delay pipe=0, blocked=0.
  - mapX=START_MAPX, mapY=START_MAPY, playerX=START_PX, playerY=START_PY.
  - collision=0, room_change=0.
- Reset released mid-frame: stay IDLE until the next frame start, so no partial scan is ever committed.
- Latency:
  - `collision` is valid 1 cycle after the delayed frame end.
  - Position, room and `room_change` update 2 cycles after the delayed frame end.
  - All outputs are stable for the rest of vertical blanking and the next frame.
- `room_change` is high for exactly one cycle, never on consecutive cycles.
- A frame start seen outside IDLE cannot occur in normal scan and is ignored.

## Test plan
- Reset: after deasserting reset, read mapX=3, mapY=5, playerX=316, playerY=300, collision=0, room_change=0.
- Free move: mapData=0, hold btn_right for one frame → playerX=318, playerY=300, collision=0, no room_change.
- Wall block: mapData=8'hFF for columns 324–330, rows 300–307; press right with playerX=316 → playerX stays 316, collision=1. Next frame with no button → collision=0.
- Room exit: START_PX=632, press right → mapX=4, playerX=0, room_change high for exactly 1 cycle. Press left next frame → mapX=3, playerX=632.
- World edge: START_MAPX=0, START_PX=0, press left → mapX=0, playerX=0, no pulse. Press up+down together → playerY unchanged.
- Reset mid-SCAN after a wall hit: assert reset at row 200, release at row 300 → outputs at reset values. The next full empty-map frame gives collision=0 and the move is applied.
